mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares one single-port, fixed-latency memory between the instruction-fetch port and the load/store port of the core. It serialises requests, issues them to the memory one at a time, captures read data and signals completion per port. It lets the core run from a unified memory, and it is the stall source for a multicycle fetch/execute sequence.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch port and the load/store port.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed data > fetch priority.

module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {stIdle, stIssue, stWait, stDone} stateT;

  stateT             state, nextState;
  logic [CNT_W-1:0]  latCnt;
  logic              anyReq;
  logic              grantData;
  logic              winData;
  logic              memWeQ;
  logic [1:0]        memSizeQ;
  logic [ADDR_W-1:0] memAddrQ;
  logic [DATA_W-1:0] memWdataQ;
  logic [31:0]       iRdataQ;
  logic [DATA_W-1:0] dRdataQ;
`ifdef ARB_RR_EN
  logic              lastGrantData;
`endif

  assign anyReq = i_req | d_req;

  always_comb begin
`ifdef ARB_RR_EN
    // On contention the port not granted last wins; the reset value (fetch) lets data win first.
    grantData = (d_req && i_req) ? !lastGrantData : d_req;
`else
    grantData = d_req;
`endif
  end

  always_comb begin
    // NOTE: assign a default before the case so every path drives nextState and no latch is inferred.
    nextState = state;
    case (state)
      stIdle:  if (anyReq) nextState = stIssue;
      stIssue: nextState = stWait;
      stWait:  if (latCnt == CNT_W'(1)) nextState = stDone;
      stDone:  nextState = stIdle;
      default: nextState = stIdle;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= stIdle;
      latCnt    <= '0;
      winData   <= 1'b0;
      memWeQ    <= 1'b0;
      memSizeQ  <= 2'b00;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      iRdataQ   <= '0;
      dRdataQ   <= '0;
`ifdef ARB_RR_EN
      lastGrantData <= 1'b0;
`endif
    end else begin
      state <= nextState;
      case (state)
        stIdle: begin
          if (anyReq) begin
            // Fetches are always word-sized reads.
            winData   <= grantData;
            memWeQ    <= grantData ? d_we : 1'b0;
            memSizeQ  <= grantData ? d_size : 2'b10;
            memAddrQ  <= grantData ? d_addr : i_addr;
            memWdataQ <= grantData ? d_wdata : '0;
`ifdef ARB_RR_EN
            lastGrantData <= grantData;
`endif
          end
        end
        stIssue: latCnt <= CNT_W'(MEM_LAT);
        stWait: begin
          latCnt <= latCnt - CNT_W'(1);
          // mem_rdata is valid in exactly the cycle the counter reads one.
          if (latCnt == CNT_W'(1)) begin
            if (!winData)     iRdataQ <= mem_rdata[31:0];
            else if (!memWeQ) dRdataQ <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (state == stIssue);
  assign mem_we    = memWeQ;
  assign mem_size  = memSizeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;
  assign i_valid   = (state == stDone) && !winData;
  assign d_valid   = (state == stDone) && winData;
  assign i_rdata   = iRdataQ;
  assign d_rdata   = dRdataQ;
  assign busy      = (state != stIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: a timeline reference model predicts each
// memory transaction and completion; a negedge monitor pops and compares what the DUT presents.

module tb_mem_port_arbiter;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int MEM_LAT = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_valid;
  logic [31:0]       i_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [1:0]        d_size = 2'b00;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic logic [63:0] initVal(input logic [63:0] a);
    return {a[31:0] ^ 32'h9E37_79B9, a[63:32] ^ ~a[31:0]};
  endfunction

  function automatic logic [63:0] randAddr();
    logic [31:0] hi;
    hi = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0;
    return {hi, 24'h0, 5'($urandom_range(0, 15)), 3'b000};
  endfunction

  // Memory responder: read data appears exactly MEM_LAT cycles after mem_en, junk otherwise.
  logic [63:0] memArr [logic [63:0]];
  logic [63:0] pipeData [MEM_LAT];
  logic        pipeVld  [MEM_LAT];
  logic [63:0] junk = '0;

  initial for (int k = 0; k < MEM_LAT; k++) begin pipeData[k] = '0; pipeVld[k] = 1'b0; end

  always @(posedge clock) begin
    junk <= {$urandom, $urandom};
    for (int k = MEM_LAT - 1; k > 0; k--) begin
      pipeData[k] <= pipeData[k-1];
      pipeVld[k]  <= pipeVld[k-1];
    end
    pipeVld[0]  <= mem_en && !mem_we;
    pipeData[0] <= memArr.exists(mem_addr) ? memArr[mem_addr] : initVal(mem_addr);
    if (mem_en && mem_we) memArr[mem_addr] = mem_wdata;
  end

  assign mem_rdata = pipeVld[MEM_LAT-1] ? pipeData[MEM_LAT-1] : junk;

  // Reference model: a timeline of grants with plain cycle arithmetic.
  typedef struct { longint cyc; logic we; logic [1:0] size; logic [63:0] addr; logic [63:0] wdata; } busT;
  typedef struct { longint cyc; logic isData; logic isStore; logic [63:0] rdata; } doneT;

  busT    busQ[$];
  doneT   doneQ[$];
  logic [63:0] modelMem [logic [63:0]];
  longint grantCyc = -1;
  longint nextIdle = 0;
  bit     pend[2];
  bit     inflight[2];
  longint doneC[2];
`ifdef ARB_RR_EN
  bit     lastData = 1'b0;
`endif

  function automatic logic [63:0] readModel(input logic [63:0] a);
    return modelMem.exists(a) ? modelMem[a] : initVal(a);
  endfunction

  task automatic step(input bit allowNew);
    bit winData;
    for (int p = 0; p < 2; p++) if (inflight[p] && cyc > doneC[p]) inflight[p] = 1'b0;

    if (!inflight[0] && !pend[0]) begin
      i_req = 1'b0;
      if (allowNew && $urandom_range(0, 99) < 55) begin
        pend[0] = 1'b1; i_req = 1'b1; i_addr = randAddr();
      end
    end else if (inflight[0] && i_req && $urandom_range(0, 99) < 20) begin
      i_req = 1'b0; i_addr = {$urandom, $urandom};
    end

    if (!inflight[1] && !pend[1]) begin
      d_req = 1'b0;
      if (allowNew && $urandom_range(0, 99) < 55) begin
        pend[1] = 1'b1; d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_size = 2'($urandom_range(0, 3)); d_addr = randAddr(); d_wdata = {$urandom, $urandom};
      end
    end else if (inflight[1] && d_req && $urandom_range(0, 99) < 20) begin
      d_req = 1'b0; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
      d_we = ~d_we; d_size = ~d_size;
    end

    if (cyc >= nextIdle && (pend[0] || pend[1])) begin
`ifdef ARB_RR_EN
      winData  = (pend[0] && pend[1]) ? !lastData : pend[1];
      lastData = winData;
`else
      winData = pend[1];
`endif
      pend[winData]     = 1'b0;
      inflight[winData] = 1'b1;
      doneC[winData]    = cyc + 2 + MEM_LAT;
      grantCyc          = cyc;
      nextIdle          = cyc + 3 + MEM_LAT;
      if (winData) begin
        busQ.push_back(busT'{cyc + 1, d_we, d_size, d_addr, d_wdata});
        doneQ.push_back(doneT'{cyc + 2 + MEM_LAT, 1'b1, d_we, d_we ? 64'h0 : readModel(d_addr)});
        if (d_we) modelMem[d_addr] = d_wdata;
      end else begin
        busQ.push_back(busT'{cyc + 1, 1'b0, 2'b10, i_addr, 64'h0});
        doneQ.push_back(doneT'{cyc + 2 + MEM_LAT, 1'b0, 1'b0, readModel(i_addr)});
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents mem_en or a valid.
  logic        monOn = 1'b0;
  logic [31:0] heldI = '0;
  logic [63:0] heldD = '0;
  busT         mb;
  doneT        md;

  always @(negedge clock) begin
    if (monOn && !reset) begin
      check("busy", 64'(busy), 64'(cyc > grantCyc && cyc < nextIdle));
      if (mem_en) begin
        if (busQ.size() == 0) failNow("mem_en unexpected");
        else begin
          mb = busQ.pop_front();
          check("mem_en cycle", cyc, mb.cyc);
          check("mem_we", 64'(mem_we), 64'(mb.we));
          check("mem_size", 64'(mem_size), 64'(mb.size));
          check("mem_addr", mem_addr, mb.addr);
          if (mb.we) check("mem_wdata", mem_wdata, mb.wdata);
        end
      end else if (busQ.size() > 0 && busQ[0].cyc < cyc) begin
        mb = busQ.pop_front();
        failNow("mem_en missing");
      end
      if (i_valid && d_valid) failNow("both valids");
      if (i_valid || d_valid) begin
        if (doneQ.size() == 0) failNow("valid unexpected");
        else begin
          md = doneQ.pop_front();
          check("valid cycle", cyc, md.cyc);
          check("valid port", 64'(d_valid), 64'(md.isData));
          if (md.isData && !md.isStore) heldD = md.rdata;
          if (!md.isData) heldI = md.rdata[31:0];
        end
      end else if (doneQ.size() > 0 && doneQ[0].cyc < cyc) begin
        md = doneQ.pop_front();
        failNow("valid missing");
      end
      check("i_rdata", 64'(i_rdata), 64'(heldI));
      check("d_rdata", d_rdata, heldD);
    end
  end

  task automatic clearModel();
    busQ.delete();
    doneQ.delete();
    for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; inflight[p] = 1'b0; end
    i_req = 1'b0;
    d_req = 1'b0;
    heldI = '0;
    heldD = '0;
`ifdef ARB_RR_EN
    lastData = 1'b0;
`endif
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " mem_en"}, 64'(mem_en), 64'(0));
    check({tag, " i_valid"}, 64'(i_valid), 64'(0));
    check({tag, " d_valid"}, 64'(d_valid), 64'(0));
  endtask

  bit inWait;

  initial begin
    clearModel();
    repeat (2) @(posedge clock);
    #1;
    checkIdleOutputs("reset");
    check("reset mem_we", 64'(mem_we), 64'(0));
    check("reset mem_size", 64'(mem_size), 64'(0));
    check("reset mem_addr", mem_addr, 64'(0));
    check("reset mem_wdata", mem_wdata, 64'(0));
    check("reset i_rdata", 64'(i_rdata), 64'(0));
    check("reset d_rdata", d_rdata, 64'(0));
    reset    = 1'b0;
    nextIdle = cyc;
    monOn    = 1'b1;

    for (int n = 0; n < 1500; n++) begin
      step(1'b1);
      @(posedge clock); #1;
    end

    // Drive until a transaction sits in its WAIT window, then reset asynchronously.
    inWait = 1'b0;
    for (int k = 0; k < 100 && !inWait; k++) begin
      if (grantCyc >= 0 && cyc >= grantCyc + 2 && cyc <= grantCyc + 1 + MEM_LAT) inWait = 1'b1;
      else begin
        step(1'b1);
        @(posedge clock); #1;
      end
    end
    if (!inWait) failNow("no WAIT window reached");
    reset = 1'b1;
    #1;
    checkIdleOutputs("mid reset");
    clearModel();
    repeat (2) @(posedge clock);
    #1;
    checkIdleOutputs("held reset");
    reset    = 1'b0;
    nextIdle = cyc;

    for (int n = 0; n < 400; n++) begin
      step(1'b1);
      @(posedge clock); #1;
    end

    for (int k = 0; k < 60 && (busQ.size() > 0 || doneQ.size() > 0 || pend[0] || pend[1]); k++) begin
      step(1'b0);
      @(posedge clock); #1;
    end
    if (busQ.size() > 0 || doneQ.size() > 0 || pend[0] || pend[1]) failNow("drain timeout");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
